// File: rtl/tiny_mem_arbiter_if.sv
// Native tiny-core memory bus: valid/ready request handshake, read data and
// an error flag returned alongside the completion pulse.
interface tiny_mem_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output valid, we, addr, wdata, wstrb, input ready, rdata, err);
    modport slave  (input valid, we, addr, wdata, wstrb, output ready, rdata, err);
endinterface

// File: rtl/tiny_mem_arbiter.sv
// Two-master arbiter in front of a single memory port: one registered
// downstream transaction at a time, optional watchdog on missing acknowledges.
module tiny_mem_arbiter #(
    parameter bit              RR       = 1'b1,
    parameter int unsigned     TIMEOUT  = 0,
    parameter logic [31:0]     ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                rst,
    tiny_mem_arbiter_if.slave   m0,
    tiny_mem_arbiter_if.slave   m1,
    tiny_mem_arbiter_if.master  mem
);
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              winner_c;
    logic              timeout_c;
    logic              done_c;

    // State and captured-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    // Arbitration, capture and completion
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        winner_c    = 1'b0;
        timeout_c   = 1'b0;
        done_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    if (m0.valid && m1.valid) winner_c = RR ? ~last_q : 1'b0;
                    else                      winner_c = m1.valid;
                    owner_d     = winner_c;
                    last_d      = winner_c;
                    mem_valid_d = 1'b1;
                    mem_we_d    = winner_c ? m1.we    : m0.we;
                    mem_addr_d  = winner_c ? m1.addr  : m0.addr;
                    mem_wdata_d = winner_c ? m1.wdata : m0.wdata;
                    mem_wstrb_d = winner_c ? m1.wstrb : m0.wstrb;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // A real acknowledge in the deadline cycle beats the watchdog
                timeout_c = WDOG_EN && !mem.ready && (cnt_q == CNT_LAST);
                done_c    = mem.ready || timeout_c;
                if (done_c) begin
                    mem_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion routed to the owner in the acknowledge cycle; suppressed under reset
    always_comb begin
        m0.ready = 1'b0;
        m0.err   = 1'b0;
        m0.rdata = '0;
        m1.ready = 1'b0;
        m1.err   = 1'b0;
        m1.rdata = '0;
        if (done_c && !rst) begin
            if (owner_q) begin
                m1.ready = 1'b1;
                m1.err   = timeout_c;
                m1.rdata = mem.ready ? mem.rdata : ERR_DATA;
            end else begin
                m0.ready = 1'b1;
                m0.err   = timeout_c;
                m0.rdata = mem.ready ? mem.rdata : ERR_DATA;
            end
        end
    end

    assign mem.valid = mem_valid_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign mem.wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_tiny_mem_arbiter.sv
// Scoreboard bench for tiny_mem_arbiter: instance a (round-robin, watchdog 8)
// and instance b (fixed priority, no watchdog) each behind a behavioural memory.
module tb_tiny_mem_arbiter;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        ready;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        int          d;
        int          m;
        bit          we;
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tiny_mem_arbiter_if a_m0 (), a_m1 (), a_mem ();
    tiny_mem_arbiter_if b_m0 (), b_m1 (), b_mem ();

    tiny_mem_arbiter #(.RR(1'b1), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .rst(rst), .m0(a_m0), .m1(a_m1), .mem(a_mem));
    tiny_mem_arbiter #(.RR(1'b0), .TIMEOUT(0), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst(rst), .m0(b_m0), .m1(b_m1), .mem(b_mem));

    req_t u_req [2][2];
    rsp_t u_rsp [2][2];
    req_t u_mem [2];

    assign {a_m0.valid, a_m0.we, a_m0.addr, a_m0.wdata, a_m0.wstrb} = u_req[0][0];
    assign {a_m1.valid, a_m1.we, a_m1.addr, a_m1.wdata, a_m1.wstrb} = u_req[0][1];
    assign {b_m0.valid, b_m0.we, b_m0.addr, b_m0.wdata, b_m0.wstrb} = u_req[1][0];
    assign {b_m1.valid, b_m1.we, b_m1.addr, b_m1.wdata, b_m1.wstrb} = u_req[1][1];
    assign u_rsp[0][0] = {a_m0.ready, a_m0.err, a_m0.rdata};
    assign u_rsp[0][1] = {a_m1.ready, a_m1.err, a_m1.rdata};
    assign u_rsp[1][0] = {b_m0.ready, b_m0.err, b_m0.rdata};
    assign u_rsp[1][1] = {b_m1.ready, b_m1.err, b_m1.rdata};
    assign u_mem[0] = {a_mem.valid, a_mem.we, a_mem.addr, a_mem.wdata, a_mem.wstrb};
    assign u_mem[1] = {b_mem.valid, b_mem.we, b_mem.addr, b_mem.wdata, b_mem.wstrb};

    // Memory a: word array with programmable wait states or a hang
    logic [31:0] mem_a    [256];
    logic [31:0] shadow_a [256];
    int          a_wait = 0;
    bit          a_hang = 1'b0;
    int          a_wcnt = 0;

    assign a_mem.ready = a_mem.valid && !a_hang && (a_wcnt == a_wait);
    assign a_mem.rdata = (a_mem.ready && !a_mem.we) ? mem_a[a_mem.addr[9:2]] : 32'h0;
    assign a_mem.err   = 1'b0;

    always @(posedge clk) begin
        if (rst || !a_mem.valid || a_mem.ready) a_wcnt <= 0;
        else                                    a_wcnt <= a_wcnt + 1;
        if (a_mem.valid && a_mem.ready && a_mem.we)
            for (int i = 0; i < 4; i++)
                if (a_mem.wstrb[i]) mem_a[a_mem.addr[9:2]][8*i +: 8] <= a_mem.wdata[8*i +: 8];
    end

    // Memory b: zero-wait, read data derived from the address
    assign b_mem.ready = b_mem.valid;
    assign b_mem.rdata = (b_mem.valid && !b_mem.we) ? {b_mem.addr[15:0], 16'hB0B0} : 32'h0;
    assign b_mem.err   = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   vcnt [2];
    int   lr   [2][2];
    exp_t sb [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input int d, input logic [31:0] addr);
        if (d == 0) return shadow_a[addr[9:2]];
        return {addr[15:0], 16'hB0B0};
    endfunction

    task automatic sb_push(input int d, input int m, input bit we, input logic [31:0] addr,
                           input logic [31:0] rdata, input bit err);
        exp_t e;
        e.d = d; e.m = m; e.we = we; e.addr = addr; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor: pops the scoreboard, checks owner routing and quiet outputs
    always @(negedge clk) begin : mon
        rsp_t r0, r1, other;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            r0 = u_rsp[d][0];
            r1 = u_rsp[d][1];
            if (u_mem[d].valid === 1'b1) vcnt[d]++;
            if (r0.ready === 1'b1 || r1.ready === 1'b1) begin
                check_eq("single_ready", 64'(r0.ready & r1.ready), 64'(0));
                check_eq("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("cpl_dut",   64'(d), 64'(e.d));
                    check_eq("cpl_owner", 64'(r1.ready ? 1 : 0), 64'(e.m));
                    check_eq("cpl_rdata", 64'(r1.ready ? r1.rdata : r0.rdata), 64'(e.rdata));
                    check_eq("cpl_err",   64'(r1.ready ? r1.err : r0.err), 64'(e.err));
                    check_eq("mem_addr",  64'(u_mem[d].addr), 64'(e.addr));
                    check_eq("mem_we",    64'(u_mem[d].we), 64'(e.we));
                end
                other = r1.ready ? r0 : r1;
                check_eq("nonowner_quiet", 64'({other.err, other.rdata}), 64'(0));
                lr[d][r1.ready ? 1 : 0] = cyc;
            end else begin
                check_eq("idle_quiet", 64'({r0.err, r1.err, r0.rdata | r1.rdata}), 64'(0));
            end
        end
    end

    // Drive one request and hold it until the matching ready (bounded)
    task automatic req(input int d, input int m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
        int n = 0;
        u_req[d][m] = {1'b1, we, addr, wdata, wstrb};
        do begin
            @(negedge clk);
            n++;
        end while (u_rsp[d][m].ready !== 1'b1 && n < 64);
        check_eq("req_completed", 64'(u_rsp[d][m].ready), 64'(1));
        @(posedge clk);
        #1;
        u_req[d][m].valid = 1'b0;
    endtask

    task automatic txn(input int d, input int m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        sb_push(d, m, we, addr, we ? 32'h0 : model_rdata(d, addr), 1'b0);
        if (we && d == 0) shadow_a[addr[9:2]] = wdata;
        req(d, m, we, addr, wdata, 4'hF);
    endtask

    task automatic check_mem_reset(input int d, input string tag);
        check_eq({tag, "_valid"}, 64'(u_mem[d].valid), 64'(0));
        check_eq({tag, "_we_strb_addr"}, 64'({u_mem[d].we, u_mem[d].wstrb, u_mem[d].addr}), 64'(0));
        check_eq({tag, "_wdata"}, 64'(u_mem[d].wdata), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) u_req[d][m] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int t0, v0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i]    = 32'h5A00_0000 | 32'(i);
            shadow_a[i] = 32'h5A00_0000 | 32'(i);
        end
        mem_a[8'h40]    = 32'hA1;
        shadow_a[8'h40] = 32'hA1;
        for (int d = 0; d < 2; d++) begin
            vcnt[d] = 0;
            for (int m = 0; m < 2; m++) begin
                u_req[d][m] = '0;
                lr[d][m]    = 0;
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_mem_reset(0, "rst_a");
        check_mem_reset(1, "rst_b");
        rst = 1'b0;

        // Single read with one wait state
        a_wait = 1;
        t0 = cyc; v0 = vcnt[0];
        txn(0, 0, 1'b0, 32'h100, 32'h0);
        check_eq("rd_latency", 64'(lr[0][0] - t0), 64'(2));
        check_eq("rd_valid_cycles", 64'(vcnt[0] - v0), 64'(2));

        // Zero-wait read on the fixed-priority instance
        t0 = cyc; v0 = vcnt[1];
        txn(1, 1, 1'b0, 32'h44, 32'h0);
        check_eq("b_latency", 64'(lr[1][1] - t0), 64'(1));
        check_eq("b_valid_cycles", 64'(vcnt[1] - v0), 64'(1));

        // Simultaneous writes after reset: m0 first, one idle slot, then m1
        do_reset();
        a_wait = 0;
        sb_push(0, 0, 1'b1, 32'h104, 32'h0, 1'b0);
        sb_push(0, 1, 1'b1, 32'h108, 32'h0, 1'b0);
        shadow_a[8'h41] = 32'h10;
        shadow_a[8'h42] = 32'h20;
        fork
            req(0, 0, 1'b1, 32'h104, 32'h10, 4'hF);
            req(0, 1, 1'b1, 32'h108, 32'h20, 4'hF);
        join
        check_eq("tie_gap", 64'(lr[0][1] - lr[0][0]), 64'(2));
        txn(0, 1, 1'b0, 32'h104, 32'h0);
        txn(0, 0, 1'b0, 32'h108, 32'h0);

        // Continuous contention, round-robin: strict alternation
        do_reset();
        for (int i = 0; i < 6; i++) begin
            sb_push(0, 0, 1'b0, 32'h300 + 32'(8*i), model_rdata(0, 32'h300 + 32'(8*i)), 1'b0);
            sb_push(0, 1, 1'b0, 32'h380 + 32'(8*i), model_rdata(0, 32'h380 + 32'(8*i)), 1'b0);
        end
        fork
            for (int i = 0; i < 6; i++) req(0, 0, 1'b0, 32'h300 + 32'(8*i), 32'h0, 4'hF);
            for (int i = 0; i < 6; i++) req(0, 1, 1'b0, 32'h380 + 32'(8*i), 32'h0, 4'hF);
        join

        // Same contention, fixed priority: m0 drains first
        for (int i = 0; i < 6; i++) sb_push(1, 0, 1'b0, 32'h500 + 32'(4*i), model_rdata(1, 32'h500 + 32'(4*i)), 1'b0);
        for (int i = 0; i < 6; i++) sb_push(1, 1, 1'b0, 32'h600 + 32'(4*i), model_rdata(1, 32'h600 + 32'(4*i)), 1'b0);
        fork
            for (int i = 0; i < 6; i++) req(1, 0, 1'b0, 32'h500 + 32'(4*i), 32'h0, 4'hF);
            for (int i = 0; i < 6; i++) req(1, 1, 1'b0, 32'h600 + 32'(4*i), 32'h0, 4'hF);
        join

        // Watchdog: memory never answers
        a_hang = 1'b1;
        t0 = cyc; v0 = vcnt[0];
        sb_push(0, 1, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b1);
        req(0, 1, 1'b0, 32'h200, 32'h0, 4'hF);
        check_eq("to_latency", 64'(lr[0][1] - t0), 64'(8));
        check_eq("to_valid_cycles", 64'(vcnt[0] - v0), 64'(8));
        a_hang = 1'b0;
        txn(0, 1, 1'b0, 32'h204, 32'h0);

        // Acknowledge in the deadline cycle wins over the watchdog
        a_wait = 7;
        t0 = cyc;
        txn(0, 0, 1'b0, 32'h208, 32'h0);
        check_eq("edge_latency", 64'(lr[0][0] - t0), 64'(8));
        a_wait = 0;

        // Reset in BUSY: abandoned silently, first tie afterwards goes to m0
        a_hang = 1'b1;
        u_req[0][0] = {1'b1, 1'b0, 32'h100, 32'h0, 4'hF};
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 64'(u_mem[0].valid), 64'(1));
        rst = 1'b1;
        u_req[0][0].valid = 1'b0;
        @(posedge clk);
        #1;
        check_mem_reset(0, "midrst_a");
        rst = 1'b0;
        a_hang = 1'b0;
        sb_push(0, 0, 1'b0, 32'h10C, model_rdata(0, 32'h10C), 1'b0);
        sb_push(0, 1, 1'b0, 32'h110, model_rdata(0, 32'h110), 1'b0);
        fork
            req(0, 0, 1'b0, 32'h10C, 32'h0, 4'hF);
            req(0, 1, 1'b0, 32'h110, 32'h0, 4'hF);
        join

        repeat (4) @(posedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
